// File: rtl/oam_dma_engine.sv
// OAM DMA bus initiator: copies OAM_BYTES bytes from {src_page,8'h00} into OAM
// using one read/capture/write triple per byte on the shared bus.
module oam_dma_engine #(
    parameter int unsigned ADDR_W       = 16,
    parameter int unsigned DATA_W       = 8,
    parameter logic [ADDR_W-1:0] DMA_REG_ADDR = 16'hFF46,
    parameter logic [ADDR_W-1:0] OAM_BASE     = 16'hFE00,
    parameter int unsigned OAM_BYTES    = 160
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cfg_wr,
    input  logic [ADDR_W-1:0] cfg_addr,
    input  logic [DATA_W-1:0] cfg_wdata,
    output logic [DATA_W-1:0] cfg_rdata,
    output logic              bus_req,
    input  logic              bus_gnt,
    output logic [ADDR_W-1:0] bus_addr,
    output logic              bus_rd,
    output logic              bus_wr,
    output logic [DATA_W-1:0] bus_wdata,
    input  logic [DATA_W-1:0] bus_rdata,
    output logic              busy,
    output logic              done
);

    localparam int unsigned IDX_W = 8;
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(OAM_BYTES - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_REQ,
        S_READ,
        S_CAPT,
        S_WRITE,
        S_DONE
    } state_e;

    state_e            state_q, state_d;
    logic [IDX_W-1:0]  idx_q, idx_d;
    logic [DATA_W-1:0] page_q, page_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              start;

    assign start     = cfg_wr && (cfg_addr == DMA_REG_ADDR);
    assign cfg_rdata = page_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= S_IDLE;
            idx_q   <= '0;
            page_q  <= '0;
            data_q  <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            page_q  <= page_d;
            data_q  <= data_d;
        end
    end

    // Strobes are qualified by the live grant so they never fire without the bus.
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        page_d    = page_q;
        data_d    = data_q;
        bus_req   = 1'b0;
        bus_rd    = 1'b0;
        bus_wr    = 1'b0;
        bus_addr  = '0;
        bus_wdata = '0;
        busy      = 1'b0;
        done      = 1'b0;

        case (state_q)
            S_IDLE: ;
            S_REQ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) state_d = S_READ;
            end
            S_READ: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) begin
                    bus_rd   = 1'b1;
                    bus_addr = ADDR_W'({page_q, 8'h00}) + ADDR_W'(idx_q);
                    state_d  = S_CAPT;
                end
            end
            S_CAPT: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                data_d  = bus_rdata;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                bus_req = 1'b1;
                busy    = 1'b1;
                if (bus_gnt) begin
                    bus_wr    = 1'b1;
                    bus_addr  = OAM_BASE + ADDR_W'(idx_q);
                    bus_wdata = data_q;
                    if (idx_q == LAST_IDX) begin
                        idx_d   = '0;
                        state_d = S_DONE;
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                        state_d = S_READ;
                    end
                end
            end
            S_DONE: begin
                done    = 1'b1;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase

        // A register write restarts from byte 0 and overrides any pending done.
        if (start) begin
            page_d  = cfg_wdata;
            idx_d   = '0;
            state_d = S_REQ;
            done    = 1'b0;
        end
    end

endmodule

// File: tb/tb_oam_dma_engine.sv
// Directed bench for oam_dma_engine: bus memory model, OAM shadow and
// protocol monitor, with immediate-assertion checks at each step.
module tb_oam_dma_engine;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cfg_wr = 1'b0;
    logic [15:0] cfg_addr = '0;
    logic [7:0]  cfg_wdata = '0;
    logic [7:0]  cfg_rdata;
    logic        bus_req;
    logic        bus_gnt = 1'b0;
    logic [15:0] bus_addr;
    logic        bus_rd;
    logic        bus_wr;
    logic [7:0]  bus_wdata;
    logic [7:0]  bus_rdata = '0;
    logic        busy;
    logic        done;

    int tests = 0;
    int fails = 0;
    int wr_cnt = 0;
    int done_cnt = 0;
    int viol = 0;
    logic [7:0] oam [0:159];
    logic [7:0] rtg_rdata = '0;
    logic       stall_rd_ok = 1'b0;
    logic       stall_wr_ok = 1'b0;

    oam_dma_engine dut (
        .clk(clk), .reset_n(reset_n),
        .cfg_wr(cfg_wr), .cfg_addr(cfg_addr), .cfg_wdata(cfg_wdata), .cfg_rdata(cfg_rdata),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus_addr(bus_addr),
        .bus_rd(bus_rd), .bus_wr(bus_wr), .bus_wdata(bus_wdata), .bus_rdata(bus_rdata),
        .busy(busy), .done(done)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] src_byte(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    // Memory returns data the cycle after bus_rd; 8'hEE otherwise to expose stale captures.
    always @(posedge clk) begin
        bus_rdata <= bus_rd ? src_byte(bus_addr) : 8'hEE;
        if (bus_wr) begin
            wr_cnt <= wr_cnt + 1;
            if (bus_addr >= 16'hFE00 && bus_addr < 16'hFEA0)
                oam[8'(bus_addr - 16'hFE00)] <= bus_wdata;
            else
                viol <= viol + 1;
        end
        if (bus_rd && (bus_addr[15:8] !== cfg_rdata || bus_addr[7:0] >= 8'd160))
            viol <= viol + 1;
        if ((bus_rd && bus_wr) || ((bus_rd || bus_wr) && !bus_gnt))
            viol <= viol + 1;
        if (done) done_cnt <= done_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_oam(input string tag, input logic [7:0] page);
        int bad = 0;
        for (int i = 0; i < 160; i++)
            if (oam[i] !== src_byte({page, 8'(i)})) bad++;
        chk(tag, 32'(bad), 32'd0);
    endtask

    // One-cycle CPU register write; returns at the falling edge after the write edge.
    task automatic cpu_wr(input logic [15:0] a, input logic [7:0] d);
        cfg_wr = 1'b1; cfg_addr = a; cfg_wdata = d;
        @(negedge clk);
        cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0;
    endtask

    // Cycle counter n is 1 on entry (one edge after the start write).
    task automatic run(input int mode, input int limit, output int n, output int last_wr_n,
                       output logic [15:0] last_wr_addr);
        n = 1; last_wr_n = -1; last_wr_addr = '0;
        while (done !== 1'b1 && n < limit) begin
            @(negedge clk);
            n++;
            if (bus_wr === 1'b1) begin
                last_wr_n = n;
                last_wr_addr = bus_addr;
            end
            if (mode == 3) begin
                if (n == 33) stall_rd_ok = (bus_rd === 1'b0) && (bus_req === 1'b1);
                if (n == 70) stall_wr_ok = (bus_wr === 1'b0) && (busy === 1'b1);
                if (n == 32 || n == 69) bus_gnt = 1'b0;
                if (n == 37 || n == 72) bus_gnt = 1'b1;
            end
            if (mode == 4) begin
                if (n == 153) rtg_rdata = cfg_rdata;
                if (n == 152) begin cfg_wr = 1'b1; cfg_addr = 16'hFF46; cfg_wdata = 8'hD0; end
                if (n == 153) begin cfg_wr = 1'b0; cfg_addr = '0; cfg_wdata = '0; end
            end
        end
    endtask

    initial begin
        int n, lw_n, w0, d0;
        logic [15:0] lw_a;

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_bus_req", 32'(bus_req), 0);
        chk("rst_bus_rd", 32'(bus_rd), 0);
        chk("rst_bus_wr", 32'(bus_wr), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_done", 32'(done), 0);
        chk("rst_bus_addr", 32'(bus_addr), 0);
        chk("rst_cfg_rdata", 32'(cfg_rdata), 0);
        reset_n = 1'b1;
        @(negedge clk);

        // Reset during the idx 40 write
        bus_gnt = 1'b1;
        w0 = wr_cnt;
        cpu_wr(16'hFF46, 8'hC0);
        run(0, 124, n, lw_n, lw_a);
        chk("t1_wr_at_idx40", 32'(bus_wr), 1);
        chk("t1_addr_at_idx40", 32'(bus_addr), 32'h0000_FE28);
        reset_n = 1'b0;
        #1;
        chk("t1_rst_bus_wr", 32'(bus_wr), 0);
        chk("t1_rst_bus_req", 32'(bus_req), 0);
        chk("t1_rst_busy", 32'(busy), 0);
        chk("t1_rst_bus_addr", 32'(bus_addr), 0);
        chk("t1_rst_cfg_rdata", 32'(cfg_rdata), 0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("t1_idle_busy", 32'(busy), 0);
        chk("t1_idle_req", 32'(bus_req), 0);
        chk("t1_writes", 32'(wr_cnt - w0), 32'd40);

        // Basic copy with grant tied high, plus last-byte behaviour
        w0 = wr_cnt;
        cpu_wr(16'hFF46, 8'hC0);
        chk("t2_req_no_strobe", 32'({bus_req, bus_rd, bus_wr}), 32'b100);
        run(0, 600, n, lw_n, lw_a);
        chk("t2_done_seen", 32'(done), 1);
        chk("t2_done_cycle", 32'(n), 32'd482);
        chk("t6_last_wr_cycle", 32'(lw_n), 32'd481);
        chk("t6_last_wr_addr", 32'(lw_a), 32'h0000_FE9F);
        chk("t6_done_req", 32'(bus_req), 0);
        chk("t6_done_busy", 32'(busy), 0);
        d0 = done_cnt;
        @(negedge clk);
        chk("t6_done_pulse_len", 32'(done), 0);
        chk("t2_done_count", 32'(done_cnt - d0), 32'd1);
        chk("t2_writes", 32'(wr_cnt - w0), 32'd160);
        chk("t2_cfg_rdata", 32'(cfg_rdata), 32'h0000_00C0);
        chk_oam("t2_oam_data", 8'hC0);
        chk("t2_protocol", 32'(viol), 0);

        // Grant stalls in READ (idx 10) and WRITE (idx 20)
        cpu_wr(16'hFF46, 8'hC8);
        run(3, 600, n, lw_n, lw_a);
        chk("t3_done_cycle", 32'(n), 32'd490);
        chk("t3_stall_rd", 32'(stall_rd_ok), 1);
        chk("t3_stall_wr", 32'(stall_wr_ok), 1);
        @(negedge clk);
        chk_oam("t3_oam_data", 8'hC8);
        chk("t3_protocol", 32'(viol), 0);

        // Retrigger at idx 50 with a new page
        d0 = done_cnt;
        cpu_wr(16'hFF46, 8'hC0);
        run(4, 800, n, lw_n, lw_a);
        chk("t4_done_cycle", 32'(n), 32'd634);
        chk("t4_rdata_update", 32'(rtg_rdata), 32'h0000_00D0);
        @(negedge clk);
        chk("t4_done_count", 32'(done_cnt - d0), 32'd1);
        chk_oam("t4_oam_data", 8'hD0);
        chk("t4_protocol", 32'(viol), 0);

        // Address decode and readback
        cpu_wr(16'hFF47, 8'h12);
        chk("t5_no_req", 32'(bus_req), 0);
        chk("t5_no_busy", 32'(busy), 0);
        chk("t5_rdata_kept", 32'(cfg_rdata), 32'h0000_00D0);
        cpu_wr(16'hFF46, 8'h80);
        chk("t5_rdata_new", 32'(cfg_rdata), 32'h0000_0080);
        chk("t5_busy", 32'(busy), 1);
        run(0, 600, n, lw_n, lw_a);
        chk("t5_done_cycle", 32'(n), 32'd482);
        @(negedge clk);
        chk_oam("t5_oam_data", 8'h80);
        chk("t5_protocol", 32'(viol), 0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
